// File: rtl/config_sequencer_if.sv
// config_sequencer_if -- bundles every config_sequencer signal except clk/rstn.
//
// Optional macro: CFG_ACTIVE_MASK_EN adds the active_mask member.
//
// Members (driven by master, observed by slave unless noted):
//   chip_en, start_exec, trigger_in : global enable, program start level, advance qualifier
//   wr_en_op, wr_en_r, wr_addr,
//   wr_data_op, wr_data_r           : config memory write port (IDLE only)
//   loop_end, vec_size              : loop bound and vector length minus 1
//   active_mask                     : per-address enable (CFG_ACTIVE_MASK_EN only)
//   ctrl_op, ctrl_r, addr_op,
//   vec_cnt, busy, dbg_state        : outputs of the slave (sequencer)
//
// Handshake: there is no valid/ready pair. trigger_in is sampled on each clk
// edge while running; 1 means "consume one step now", 0 means "hold".
// chip_en=0 suppresses every update, including writes.
interface config_sequencer_if #(
  parameter int CM_WIDTH_OP = 24,
  parameter int NUM_CH      = 4,
  parameter int SEL_BITS    = 4,
  parameter int TRIG_BITS   = 3,
  parameter int CM_DEPTH    = 8,
  parameter int VEC_WIDTH   = 4
);
  localparam int AW = (CM_DEPTH > 1) ? $clog2(CM_DEPTH) : 1;
  localparam int VB = (VEC_WIDTH > 1) ? $clog2(VEC_WIDTH) : 1;

  logic                                   chip_en;
  logic                                   start_exec;
  logic                                   trigger_in;
  logic                                   wr_en_op;
  logic                                   wr_en_r;
  logic [AW-1:0]                          wr_addr;
  logic [CM_WIDTH_OP-1:0]                 wr_data_op;
  logic [NUM_CH*(SEL_BITS+TRIG_BITS)-1:0] wr_data_r;
  logic [AW-1:0]                          loop_end;
  logic [VB-1:0]                          vec_size;
`ifdef CFG_ACTIVE_MASK_EN
  logic [CM_DEPTH-1:0]                    active_mask;
`endif
  logic [CM_WIDTH_OP-1:0]                 ctrl_op;
  logic [NUM_CH*SEL_BITS-1:0]             ctrl_r;
  logic [AW-1:0]                          addr_op;
  logic [VB-1:0]                          vec_cnt;
  logic                                   busy;
  logic [1:0]                             dbg_state;

  modport master (
`ifdef CFG_ACTIVE_MASK_EN
    output active_mask,
`endif
    output chip_en, start_exec, trigger_in, wr_en_op, wr_en_r, wr_addr,
    output wr_data_op, wr_data_r, loop_end, vec_size,
    input  ctrl_op, ctrl_r, addr_op, vec_cnt, busy, dbg_state
  );

  modport slave (
`ifdef CFG_ACTIVE_MASK_EN
    input  active_mask,
`endif
    input  chip_en, start_exec, trigger_in, wr_en_op, wr_en_r, wr_addr,
    input  wr_data_op, wr_data_r, loop_end, vec_size,
    output ctrl_op, ctrl_r, addr_op, vec_cnt, busy, dbg_state
  );
endinterface

// File: rtl/config_sequencer.sv
// config_sequencer -- single-clock PE configuration sequencer for a CGRA tile.
//
// Holds an operation memory and an NUM_CH-channel routing memory, steps through
// them with loop bound / vector sub-step / NOP hold counters and drives the PE
// operation word and per-channel routing selects. Clock enables only.
//
// Optional macro: CFG_ACTIVE_MASK_EN -- per-address active mask; inactive words
// present IDLE_OP, do not update routing and have their NOP field read as 0.
//
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : config_sequencer_if.slave (controls, write port, outputs, dbg_state)
module config_sequencer #(
  parameter int                     CM_WIDTH_OP = 24,
  parameter int                     NOP_BITS    = 3,
  parameter int                     NUM_CH      = 4,
  parameter int                     SEL_BITS    = 4,
  parameter int                     TRIG_BITS   = 3,
  parameter int                     CM_DEPTH    = 8,
  parameter int                     VEC_WIDTH   = 4,
  parameter logic [CM_WIDTH_OP-1:0] IDLE_OP     = 24'h000FFF
) (
  input  logic               clk,
  input  logic               rstn,
  config_sequencer_if.slave  bus
);
  localparam int AW = (CM_DEPTH > 1) ? $clog2(CM_DEPTH) : 1;
  localparam int VB = (VEC_WIDTH > 1) ? $clog2(VEC_WIDTH) : 1;
  localparam int RW = SEL_BITS + TRIG_BITS;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       start_prev_q, start_prev_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [VB-1:0]              vec_q, vec_d;
  logic [NOP_BITS-1:0]        nop_q, nop_d;
  logic [CM_WIDTH_OP-1:0]     op_q, op_d;
  logic [NUM_CH*SEL_BITS-1:0] r_q, r_d;

  logic [CM_WIDTH_OP-1:0]     mem_op [CM_DEPTH];
  logic [NUM_CH*RW-1:0]       mem_r  [CM_DEPTH];

  logic [AW-1:0]              eff_end;
  logic [NOP_BITS-1:0]        nop_field;
  logic [NUM_CH*RW-1:0]       r_word;
  logic                       cur_active;
  logic                       nxt_active;
  logic                       load_r;

`ifdef CFG_ACTIVE_MASK_EN
  assign cur_active = bus.active_mask[addr_q];
  assign nxt_active = bus.active_mask[addr_d];
`else
  assign cur_active = 1'b1;
  assign nxt_active = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    start_prev_d = start_prev_q;
    addr_d       = addr_q;
    vec_d        = vec_q;
    nop_d        = nop_q;
    op_d         = op_q;
    r_d          = r_q;
    load_r       = 1'b0;
    eff_end      = (bus.loop_end > LAST_ADDR) ? LAST_ADDR : bus.loop_end;
    nop_field    = cur_active ? op_q[CM_WIDTH_OP-1 -: NOP_BITS] : '0;

    if (bus.chip_en) begin
      start_prev_d = bus.start_exec;
      if (state_q != ST_IDLE && !bus.start_exec) begin
        state_d = ST_IDLE;
        addr_d  = '0;
        vec_d   = '0;
        nop_d   = '0;
        op_d    = IDLE_OP;
        r_d     = '1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.start_exec && !start_prev_q) state_d = ST_PRIME;
          end
          ST_PRIME: begin
            state_d = ST_RUN;
            addr_d  = '0;
            vec_d   = '0;
            nop_d   = '0;
            op_d    = mem_op[0];
            load_r  = 1'b1;
          end
          ST_RUN: begin
            if (bus.trigger_in) begin
              load_r = 1'b1;
              if (vec_q < bus.vec_size) begin
                vec_d = vec_q + VB'(1);
              end else begin
                vec_d = '0;
                if (nop_q < nop_field) begin
                  nop_d = nop_q + NOP_BITS'(1);
                end else begin
                  nop_d  = '0;
                  addr_d = (addr_q == eff_end) ? '0 : addr_q + AW'(1);
                  // Fetch with the address so ctrl_op never lags addr_op.
                  op_d   = mem_op[addr_d];
                end
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // A channel picks up its select when the step being entered matches its
    // trigger offset for the word being entered; offsets beyond vec_size
    // never match, so that channel holds.
    r_word = mem_r[addr_d];
    if (load_r && nxt_active) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (32'(r_word[c*RW+SEL_BITS +: TRIG_BITS]) == 32'(vec_d))
          r_d[c*SEL_BITS +: SEL_BITS] = r_word[c*RW +: SEL_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      addr_q       <= '0;
      vec_q        <= '0;
      nop_q        <= '0;
      op_q         <= IDLE_OP;
      r_q          <= '1;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      addr_q       <= addr_d;
      vec_q        <= vec_d;
      nop_q        <= nop_d;
      op_q         <= op_d;
      r_q          <= r_d;
    end
  end

  // Config memories: not reset, writable only while idle and enabled.
  always_ff @(posedge clk) begin
    if (bus.chip_en && state_q == ST_IDLE && bus.wr_addr <= LAST_ADDR) begin
      if (bus.wr_en_op) mem_op[bus.wr_addr] <= bus.wr_data_op;
      if (bus.wr_en_r)  mem_r[bus.wr_addr]  <= bus.wr_data_r;
    end
  end

  assign bus.ctrl_op   = cur_active ? op_q : IDLE_OP;
  assign bus.ctrl_r    = r_q;
  assign bus.addr_op   = addr_q;
  assign bus.vec_cnt   = vec_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dbg_state = state_q;
endmodule
